// File: rtl/traffic_request_encoder.sv
// -----------------------------------------------------------------------------
// traffic_request_encoder
//
// Front end for the traffic controller. It conditions the raw field signals
// (vehicle sensors, pedestrian buttons, police switch, emergency detector) and
// produces the controller's request inputs.
//   - Every raw input passes a 2-flop synchroniser, then a per-input debounce
//     counter. The debounced level changes only after DEB_CYCLES stable cycles.
//   - A pedestrian request is latched on a debounced press. It is held until
//     the controller pulses serve_m / serve_c. A set in the same cycle as a
//     clear wins.
//   - Debounced rising edges of Cm / Cc are counted as arrivals over a
//     WIN_CYCLES window. These counters saturate. At each window wrap the
//     counts are encoded into CarRatio.
//
// Ports
//   clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   raw_cm     in   raw main-road vehicle sensor (asynchronous)
//   raw_cc     in   raw side-road vehicle sensor (asynchronous)
//   raw_pqm    in   raw main-crossing pedestrian button (asynchronous)
//   raw_pqc    in   raw side-crossing pedestrian button (asynchronous)
//   raw_pol    in   raw police override switch (asynchronous)
//   raw_av     in   raw emergency-vehicle detector (asynchronous)
//   serve_m    in   1-cycle pulse: main pedestrian phase served
//   serve_c    in   1-cycle pulse: side pedestrian phase served
//   Cm, Cc     out  debounced vehicle presence
//   PQm, PQc   out  latched pedestrian requests
//   Police, AV out  debounced override / emergency levels
//   CarRatio   out  [1:0] ratio code of the last completed window
//                   3 = idle, 1 = main heavy, 2 = side heavy, 0 = balanced
//   emg        out  Police | AV, delayed by one register
// -----------------------------------------------------------------------------
module traffic_request_encoder #(
    parameter int DEB_CYCLES = 4,
    parameter int WIN_CYCLES = 64,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       raw_cm,
    input  logic       raw_cc,
    input  logic       raw_pqm,
    input  logic       raw_pqc,
    input  logic       raw_pol,
    input  logic       raw_av,
    input  logic       serve_m,
    input  logic       serve_c,
    output logic       Cm,
    output logic       Cc,
    output logic       PQm,
    output logic       PQc,
    output logic       Police,
    output logic       AV,
    output logic [1:0] CarRatio,
    output logic       emg
);

    localparam int NUM_IN  = 6;
    localparam int IDX_CM  = 0;
    localparam int IDX_CC  = 1;
    localparam int IDX_PQM = 2;
    localparam int IDX_PQC = 3;
    localparam int IDX_POL = 4;
    localparam int IDX_AV  = 5;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int WIN_W = $clog2(WIN_CYCLES);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // -------------------------------------------------------------------------
    // Synchroniser and debounce
    // -------------------------------------------------------------------------
    logic [NUM_IN-1:0]             raw_vec;
    logic [NUM_IN-1:0]             sync1_q, sync2_q;
    logic [NUM_IN-1:0]             deb_q, deb_d;
    logic [NUM_IN-1:0]             rise;
    logic [NUM_IN-1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;

    assign raw_vec = {raw_av, raw_pol, raw_pqc, raw_pqm, raw_cc, raw_cm};

    // NOTE: every variable written in a combinational block gets a default
    // first. Without the default, a path that skips the assignment would
    // infer a latch.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        rise      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            // The counter runs only while the synced input disagrees with
            // the debounced level. Agreement at any point restarts the count.
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    rise[i]  = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample values from before the edge, so the order of the
    // statements does not matter.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= raw_vec;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Pedestrian latches and emergency register
    // -------------------------------------------------------------------------
    logic pqm_q, pqm_d;
    logic pqc_q, pqc_d;
    logic emg_q, emg_d;

    // A set on a debounced press takes priority over a serve in the same
    // cycle. A serve while the latch is clear has no effect.
    always_comb begin
        pqm_d = rise[IDX_PQM] | (pqm_q & ~serve_m);
        pqc_d = rise[IDX_PQC] | (pqc_q & ~serve_c);
        emg_d = deb_q[IDX_POL] | deb_q[IDX_AV];
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pqm_q <= 1'b0;
            pqc_q <= 1'b0;
            emg_q <= 1'b0;
        end else begin
            pqm_q <= pqm_d;
            pqc_q <= pqc_d;
            emg_q <= emg_d;
        end
    end

    // -------------------------------------------------------------------------
    // Arrival window and CarRatio encoding
    // -------------------------------------------------------------------------
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_m_q, cnt_m_d;
    logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
    logic [1:0]       ratio_q, ratio_d;
    logic             wrap;

    // The comparisons use one extra bit, so 2*count cannot overflow.
    function automatic logic [1:0] encode_ratio(input logic [CNT_W-1:0] m,
                                                input logic [CNT_W-1:0] c);
        logic [CNT_W:0] m_w, c_w, m_x2, c_x2;
        m_w  = {1'b0, m};
        c_w  = {1'b0, c};
        m_x2 = {m, 1'b0};
        c_x2 = {c, 1'b0};
        if (m == '0 && c == '0) begin
            return 2'd3;
        end else if (m_w >= c_x2) begin
            return 2'd1;
        end else if (c_w >= m_x2) begin
            return 2'd2;
        end else begin
            return 2'd0;
        end
    endfunction

    assign wrap = (win_q == WIN_LAST);

    always_comb begin
        win_d   = win_q + WIN_W'(1);
        cnt_m_d = cnt_m_q;
        cnt_c_d = cnt_c_q;
        ratio_d = ratio_q;
        if (wrap) begin
            // The window closes on this edge. An arrival in this same cycle
            // counts toward the new window.
            win_d   = '0;
            ratio_d = encode_ratio(cnt_m_q, cnt_c_q);
            cnt_m_d = CNT_W'(rise[IDX_CM]);
            cnt_c_d = CNT_W'(rise[IDX_CC]);
        end else begin
            if (rise[IDX_CM] && cnt_m_q != CNT_MAX) begin
                cnt_m_d = cnt_m_q + CNT_W'(1);
            end
            if (rise[IDX_CC] && cnt_c_q != CNT_MAX) begin
                cnt_c_d = cnt_c_q + CNT_W'(1);
            end
        end
    end

    // NOTE: the asynchronous reset restarts the window mid-count. The first
    // update after release comes a full WIN_CYCLES later.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            win_q   <= '0;
            cnt_m_q <= '0;
            cnt_c_q <= '0;
            ratio_q <= '0;
        end else begin
            win_q   <= win_d;
            cnt_m_q <= cnt_m_d;
            cnt_c_q <= cnt_c_d;
            ratio_q <= ratio_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Cm       = deb_q[IDX_CM];
    assign Cc       = deb_q[IDX_CC];
    assign Police   = deb_q[IDX_POL];
    assign AV       = deb_q[IDX_AV];
    assign PQm      = pqm_q;
    assign PQc      = pqc_q;
    assign emg      = emg_q;
    assign CarRatio = ratio_q;

endmodule

// File: tb/tb_traffic_request_encoder.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_request_encoder.
// Two instances share the same stimulus:
//   inst 0: DEB_CYCLES=4, WIN_CYCLES=16, CNT_W=4
//   inst 1: DEB_CYCLES=1, WIN_CYCLES=64, CNT_W=4
//           Arrivals are fast enough here to reach counter saturation.
// The reference model holds a short history of synchronised samples for each
// input. A debounced level flips once the last DEB samples all disagree with
// it. Windows are counted with plain integers.
// -----------------------------------------------------------------------------
module tb_traffic_request_encoder;

    logic       clk = 1'b0;
    logic       Reset;
    logic [5:0] raw;        // {av, pol, pqc, pqm, cc, cm}
    logic       serve_m, serve_c;

    logic       cm[2], cc[2], pqm[2], pqc[2], pol[2], av[2], emg[2];
    logic [1:0] ratio[2];

    always #5 clk = ~clk;

    traffic_request_encoder #(.DEB_CYCLES(4), .WIN_CYCLES(16), .CNT_W(4)) dut0 (
        .clk(clk), .Reset(Reset),
        .raw_cm(raw[0]), .raw_cc(raw[1]), .raw_pqm(raw[2]), .raw_pqc(raw[3]),
        .raw_pol(raw[4]), .raw_av(raw[5]), .serve_m(serve_m), .serve_c(serve_c),
        .Cm(cm[0]), .Cc(cc[0]), .PQm(pqm[0]), .PQc(pqc[0]), .Police(pol[0]),
        .AV(av[0]), .CarRatio(ratio[0]), .emg(emg[0])
    );

    traffic_request_encoder #(.DEB_CYCLES(1), .WIN_CYCLES(64), .CNT_W(4)) dut1 (
        .clk(clk), .Reset(Reset),
        .raw_cm(raw[0]), .raw_cc(raw[1]), .raw_pqm(raw[2]), .raw_pqc(raw[3]),
        .raw_pol(raw[4]), .raw_av(raw[5]), .serve_m(serve_m), .serve_c(serve_c),
        .Cm(cm[1]), .Cc(cc[1]), .PQm(pqm[1]), .PQc(pqc[1]), .Police(pol[1]),
        .AV(av[1]), .CarRatio(ratio[1]), .emg(emg[1])
    );

    // ---------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // --------------------------------------------------------- reference model
    localparam int CNT_MAX = 15;

    function automatic int deb_of(input int n);
        return (n == 0) ? 4 : 1;
    endfunction

    function automatic int win_of(input int n);
        return (n == 0) ? 16 : 64;
    endfunction

    function automatic int ratio_of(input int m, input int c);
        if (m == 0 && c == 0) return 3;
        if (m >= 2 * c)       return 1;
        if (c >= 2 * m)       return 2;
        return 0;
    endfunction

    logic [5:0] m_r1, m_r2;          // raw sampled one and two edges ago
    bit [3:0]   m_sh  [2][6];        // newest synced sample in bit 0
    bit         m_lvl [2][6];
    bit [1:0]   m_pq  [2];           // [0]=PQm, [1]=PQc
    bit         m_emg [2];
    int         m_cnt_m[2], m_cnt_c[2], m_win[2], m_ratio[2];

    task automatic model_reset();
        m_r1 = '0;
        m_r2 = '0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 6; i++) begin
                m_sh[n][i]  = '0;
                m_lvl[n][i] = 1'b0;
            end
            m_pq[n]    = '0;
            m_emg[n]   = 1'b0;
            m_cnt_m[n] = 0;
            m_cnt_c[n] = 0;
            m_win[n]   = 0;
            m_ratio[n] = 0;
        end
    endtask

    task automatic model_step();
        for (int n = 0; n < 2; n++) begin
            bit rise [6];
            bit old_emg;
            old_emg = m_lvl[n][4] | m_lvl[n][5];
            for (int i = 0; i < 6; i++) begin
                bit all_diff;
                m_sh[n][i] = {m_sh[n][i][2:0], m_r2[i]};
                all_diff = 1'b1;
                for (int k = 0; k < deb_of(n); k++)
                    if (m_sh[n][i][k] == m_lvl[n][i]) all_diff = 1'b0;
                rise[i] = all_diff && !m_lvl[n][i];
                if (all_diff) m_lvl[n][i] = !m_lvl[n][i];
            end
            m_emg[n] = old_emg;
            if (rise[2])      m_pq[n][0] = 1'b1;
            else if (serve_m) m_pq[n][0] = 1'b0;
            if (rise[3])      m_pq[n][1] = 1'b1;
            else if (serve_c) m_pq[n][1] = 1'b0;
            if (m_win[n] == win_of(n) - 1) begin
                m_ratio[n] = ratio_of(m_cnt_m[n], m_cnt_c[n]);
                m_cnt_m[n] = rise[0] ? 1 : 0;
                m_cnt_c[n] = rise[1] ? 1 : 0;
                m_win[n]   = 0;
            end else begin
                if (rise[0] && m_cnt_m[n] < CNT_MAX) m_cnt_m[n]++;
                if (rise[1] && m_cnt_c[n] < CNT_MAX) m_cnt_c[n]++;
                m_win[n]++;
            end
        end
        m_r2 = m_r1;
        m_r1 = raw;
    endtask

    task automatic compare_all();
        for (int n = 0; n < 2; n++) begin
            check($sformatf("Cm%0d", n),       32'(cm[n]),    32'(m_lvl[n][0]));
            check($sformatf("Cc%0d", n),       32'(cc[n]),    32'(m_lvl[n][1]));
            check($sformatf("PQm%0d", n),      32'(pqm[n]),   32'(m_pq[n][0]));
            check($sformatf("PQc%0d", n),      32'(pqc[n]),   32'(m_pq[n][1]));
            check($sformatf("Police%0d", n),   32'(pol[n]),   32'(m_lvl[n][4]));
            check($sformatf("AV%0d", n),       32'(av[n]),    32'(m_lvl[n][5]));
            check($sformatf("emg%0d", n),      32'(emg[n]),   32'(m_emg[n]));
            check($sformatf("CarRatio%0d", n), 32'(ratio[n]), 32'(m_ratio[n]));
        end
    endtask

    // Advance one clock. Inputs are driven at posedge+1, and outputs are
    // sampled at the same point of the following cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (Reset) model_step();
        else       model_reset();
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // ---------------------------------------------------------------- stimulus
    int hold[6];

    initial begin
        Reset   = 1'b0;
        raw     = '0;
        serve_m = 1'b0;
        serve_c = 1'b0;
        model_reset();
        run(3);
        Reset = 1'b1;

        // Short pedestrian press is filtered; a long one latches at +6.
        raw[2] = 1'b1; run(3);
        raw[2] = 1'b0; run(10);
        check("pqm_glitch", 32'(pqm[0]), 32'd0);
        raw[2] = 1'b1; run(5);
        check("pqm_before_6", 32'(pqm[0]), 32'd0);
        run(1);
        check("pqm_at_6", 32'(pqm[0]), 32'd1);
        run(4);
        raw[2] = 1'b0; run(8);
        serve_m = 1'b1; run(1);
        serve_m = 1'b0;
        check("pqm_served", 32'(pqm[0]), 32'd0);
        run(2);

        // The press edge coincides with serve_c while PQc is pending: set wins.
        raw[3] = 1'b1; run(8);
        raw[3] = 1'b0; run(8);
        check("pqc_pending", 32'(pqc[0]), 32'd1);
        raw[3] = 1'b1; run(5);
        serve_c = 1'b1; run(1);
        serve_c = 1'b0;
        check("pqc_set_wins", 32'(pqc[0]), 32'd1);
        raw[3] = 1'b0; run(8);
        serve_c = 1'b1; run(1);
        check("pqc_cleared", 32'(pqc[0]), 32'd0);
        run(1);
        serve_c = 1'b0;
        check("pqc_serve_idle", 32'(pqc[0]), 32'd0);

        // Police and AV together: levels at +6, emg at +7.
        raw[4] = 1'b1; raw[5] = 1'b1; run(5);
        check("av_before_6", 32'(av[0]), 32'd0);
        run(1);
        check("av_at_6", 32'(av[0]), 32'd1);
        check("pol_at_6", 32'(pol[0]), 32'd1);
        check("emg_at_6", 32'(emg[0]), 32'd0);
        run(1);
        check("emg_at_7", 32'(emg[0]), 32'd1);
        raw[4] = 1'b0; raw[5] = 1'b0; run(12);

        // Burst of fast main arrivals. With DEB=1 this saturates inst 1's counter.
        for (int i = 0; i < 50; i++) begin
            raw[0] = ~raw[0];
            if (i % 4 == 0) raw[1] = ~raw[1];
            run(1);
        end
        raw[0] = 1'b0; raw[1] = 1'b0; run(140);

        // Random level holds of 1..12 cycles give glitches and real edges.
        for (int i = 0; i < 6; i++) hold[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 6; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 12));
                end else begin
                    hold[i]--;
                end
            end
            serve_m = ($urandom_range(0, 7) == 0);
            serve_c = ($urandom_range(0, 7) == 0);
            run(1);
        end
        raw = '0; serve_m = 1'b0; serve_c = 1'b0;
        run(20);

        // Assert reset mid-window with PQm pending; all outputs clear at once.
        raw[2] = 1'b1; run(8);
        raw[2] = 1'b0; run(6);
        check("pqm_before_reset", 32'(pqm[0]), 32'd1);
        run(3);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        for (int n = 0; n < 2; n++) begin
            check($sformatf("rst_Cm%0d", n),       32'(cm[n]),    32'd0);
            check($sformatf("rst_Cc%0d", n),       32'(cc[n]),    32'd0);
            check($sformatf("rst_PQm%0d", n),      32'(pqm[n]),   32'd0);
            check($sformatf("rst_PQc%0d", n),      32'(pqc[n]),   32'd0);
            check($sformatf("rst_Police%0d", n),   32'(pol[n]),   32'd0);
            check($sformatf("rst_AV%0d", n),       32'(av[n]),    32'd0);
            check($sformatf("rst_emg%0d", n),      32'(emg[n]),   32'd0);
            check($sformatf("rst_CarRatio%0d", n), 32'(ratio[n]), 32'd0);
        end
        run(2);
        Reset = 1'b1;
        // The first window after release closes on the 16th edge.
        run(15);
        check("ratio_hold_15", 32'(ratio[0]), 32'd0);
        run(1);
        check("ratio_update_16", 32'(ratio[0]), 32'd3);
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
